// File: rtl/pc_fetch_stage.sv
// Instruction fetch stage: drives the instruction-memory request, tracks the fetch PC
// and owns the IF/ID pipeline register, absorbing stalls, redirects and slow memory.
module pc_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] npc_i,
    input  logic        redirect_i,
    input  logic        stall_i,
    output logic [31:0] pc_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    input  logic        imem_ready_i,
    output logic [31:0] ifid_pc_o,
    output logic [31:0] ifid_instr_o,
    output logic        ifid_valid_o
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   buf_q, buf_d;
    logic [XLEN-1:0]   pend_q, pend_d;
    logic [XLEN-1:0]   ifid_pc_q, ifid_pc_d;
    logic [XLEN-1:0]   ifid_instr_q, ifid_instr_d;
    logic              ifid_valid_q, ifid_valid_d;
    logic              req_q, req_d;

    // State and datapath registers; reset abandons any outstanding request.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            buf_q        <= '0;
            pend_q       <= '0;
            ifid_pc_q    <= '0;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
            req_q        <= 1'b1;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            buf_q        <= buf_d;
            pend_q       <= pend_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            req_q        <= req_d;
        end
    end

    // Next-state logic; priority is redirect, then stall, then advance.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        buf_d        = buf_q;
        pend_d       = pend_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;

        case (state_q)
            FETCH: begin
                if (redirect_i) begin
                    ifid_valid_d = 1'b0;
                    ifid_instr_d = NOP_INSTR;
                    if (imem_ready_i) begin
                        pc_d = npc_i;
                    end else begin
                        // Request still in flight: its response must be swallowed first.
                        pend_d  = npc_i;
                        state_d = DRAIN;
                    end
                end else if (imem_ready_i) begin
                    if (stall_i) begin
                        buf_d   = imem_rdata_i;
                        state_d = HOLD;
                    end else begin
                        ifid_pc_d    = pc_q;
                        ifid_instr_d = imem_rdata_i;
                        ifid_valid_d = 1'b1;
                        pc_d         = npc_i;
                    end
                end else if (!stall_i) begin
                    ifid_valid_d = 1'b0;
                    ifid_instr_d = NOP_INSTR;
                end
            end

            HOLD: begin
                if (redirect_i) begin
                    ifid_valid_d = 1'b0;
                    ifid_instr_d = NOP_INSTR;
                    pc_d         = npc_i;
                    state_d      = FETCH;
                end else if (!stall_i) begin
                    ifid_pc_d    = pc_q;
                    ifid_instr_d = buf_q;
                    ifid_valid_d = 1'b1;
                    pc_d         = npc_i;
                    state_d      = FETCH;
                end
            end

            DRAIN: begin
                if (redirect_i) begin
                    pend_d = npc_i;
                end
                if (imem_ready_i) begin
                    pc_d    = redirect_i ? npc_i : pend_q;
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = FETCH;
            end
        endcase

        req_d = (state_d != HOLD);
    end

    assign pc_o         = pc_q;
    assign imem_addr_o  = pc_q;
    assign imem_req_o   = req_q;
    assign ifid_pc_o    = ifid_pc_q;
    assign ifid_instr_o = ifid_instr_q;
    assign ifid_valid_o = ifid_valid_q;

endmodule
